// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: walks a one-cold column pattern, debounces
// the first row seen low on the driven column, and reports one event per press.
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 8,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int DWELL_W = $clog2(SCAN_CYCLES);
    localparam int COUNT_W = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_CYCLES - 1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    state_t             state, state_next;
    logic [1:0]         col_idx, col_idx_next;
    logic [1:0]         row_idx, row_idx_next;
    logic [DWELL_W-1:0] dwell, dwell_next;
    logic [COUNT_W-1:0] count, count_next;
    logic [3:0]         cols_next;
    logic               key_valid_next;
    logic [3:0]         key_code_next;
    logic               key_held_next;

    logic [1:0]         col_after;
    logic               any_low;
    logic [1:0]         low_idx;
    logic               captured_low;

    function automatic logic [3:0] col_pattern(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    // Lowest-numbered low row wins when several keys share the driven column.
    always_comb begin
        any_low = (rows != 4'hF);
        if (!rows[0])
            low_idx = 2'd0;
        else if (!rows[1])
            low_idx = 2'd1;
        else if (!rows[2])
            low_idx = 2'd2;
        else
            low_idx = 2'd3;
    end

    assign captured_low = ~rows[row_idx];
    assign col_after    = col_idx + 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            dwell     <= '0;
            count     <= '0;
            cols      <= 4'b1110;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_next;
            col_idx   <= col_idx_next;
            row_idx   <= row_idx_next;
            dwell     <= dwell_next;
            count     <= count_next;
            cols      <= cols_next;
            key_valid <= key_valid_next;
            key_code  <= key_code_next;
            key_held  <= key_held_next;
        end
    end

    // Leaving DEBOUNCE or RELEASE for SCAN always moves on to the following column.
    always_comb begin
        state_next     = state;
        col_idx_next   = col_idx;
        row_idx_next   = row_idx;
        dwell_next     = dwell;
        count_next     = count;
        cols_next      = cols;
        key_valid_next = 1'b0;
        key_code_next  = key_code;
        key_held_next  = key_held;

        case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_next = '0;
                    if (any_low) begin
                        row_idx_next = low_idx;
                        count_next   = '0;
                        state_next   = DEBOUNCE;
                    end else begin
                        col_idx_next = col_after;
                        cols_next    = col_pattern(col_after);
                    end
                end else begin
                    dwell_next = dwell + DWELL_ONE;
                end
            end

            DEBOUNCE: begin
                if (!captured_low) begin
                    col_idx_next = col_after;
                    cols_next    = col_pattern(col_after);
                    dwell_next   = '0;
                    state_next   = SCAN;
                end else if (count == COUNT_LAST) begin
                    key_valid_next = 1'b1;
                    key_code_next  = {row_idx, col_idx};
                    key_held_next  = 1'b1;
                    state_next     = HELD;
                end else begin
                    count_next = count + COUNT_ONE;
                end
            end

            HELD: begin
                if (!captured_low) begin
                    count_next = '0;
                    state_next = RELEASE;
                end
            end

            RELEASE: begin
                if (captured_low) begin
                    state_next = HELD;
                end else if (count == COUNT_LAST) begin
                    key_held_next = 1'b0;
                    col_idx_next  = col_after;
                    cols_next     = col_pattern(col_after);
                    dwell_next    = '0;
                    state_next    = SCAN;
                end else begin
                    count_next = count + COUNT_ONE;
                end
            end

            default: begin
                state_next = SCAN;
            end
        endcase
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Controller for a 4x4 matrix keypad: sequences the column drive lines, reads the row lines after they pass through the two-flop synchronizer, debounces press and release, and reports one registered key event per physical press.
- Sits between the synchronizer on the row inputs and the display/key-handling logic.
- Rows and columns are active-low; idle rows are pulled high on the board.

Parameters:
- SCAN_CYCLES, 8, clocks each column is driven before rows are sampled. Minimum 4, to cover the 2-cycle synchronizer latency plus settling.
- DEBOUNCE_CYCLES, 20000, consecutive stable clocks required to accept a press or a release. Minimum 2.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- rows  input  4  synchronized row lines (synchronizer output); 0 = pressed
- cols  output  4  column drive, one-cold; 0 = column driven
- key_valid  output  1  one-cycle pulse on an accepted press
- key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key; held until the next accept
- key_held  output  1  high from the accept until the release is accepted

Behaviour:
- Reset (async, reset=0) forces:
  - state=SCAN, column index=0, cols=4'b1110
  - key_valid=0, key_code=4'h0, key_held=0
  - both counters cleared
- All outputs are registered.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - Dwell counter runs 0..SCAN_CYCLES-1 with the current column driven.
  - Rows are sampled only when dwell == SCAN_CYCLES-1.
  - Sample has all rows = 1: advance column (3 wraps to 0), clear dwell, drive the next cold pattern (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - Sample has any row = 0: capture col_idx and row_idx, go to DEBOUNCE; cols stays unchanged.
  - Multiple rows low in one sample: the lowest row index wins.
- DEBOUNCE:
  - Only the captured row is watched; other rows are ignored.
  - Counter starts at 0 on entry and increments each cycle the captured row = 0.
  - Captured row = 1 on any cycle: abandon, return to SCAN at the next column, no event.
  - Counter == DEBOUNCE_CYCLES-1 with row still 0: next edge sets key_valid=1 for exactly 1 cycle, key_code={row_idx,col_idx}, key_held=1, state HELD.
- HELD:
  - Column stays driven; stay while the captured row = 0.
  - Captured row = 1: go to RELEASE with counter 0.
  - Presses on other keys (other rows, or other columns that are not being driven) are ignored; no second event.
- RELEASE:
  - Counter increments each cycle the captured row = 1.
  - Captured row = 0 before completion: return to HELD, no new key_valid.
  - Counter == DEBOUNCE_CYCLES-1: key_held=0, return to SCAN at the next column with dwell=0.
- key_code holds its value through SCAN until the next accepted press; it is never cleared except by reset.
- Reset asserted mid-debounce or mid-hold: immediate return to reset values; no key_valid is emitted afterwards for that press until a full new scan and debounce completes.
- Glitch shorter than DEBOUNCE_CYCLES on a row: never produces key_valid.
- Counters are sized by $clog2 of their parameter; no overflow is possible because each counter is compared against the terminal value and stops there.
- Press-to-event latency, from the sample cycle: DEBOUNCE_CYCLES+1 clocks.

Test Plan:
- Idle scan (SCAN_CYCLES=4, DEBOUNCE_CYCLES=16), rows=4'hF -> cols cycles 1110,1101,1011,0111, each for exactly 4 clocks, wraps back to 1110; key_valid stays 0.
- Hold row 2 low whenever col 1 is driven, for more than 16 clocks -> scan stops at cols=1101; single key_valid pulse 17 clocks after the sample; key_code=4'b1001; key_held=1.
- Same key with a 10-clock bounce (row low 5 cycles, then high 1 cycle, repeated) -> no key_valid until a 16-cycle stable stretch; exactly one pulse total.
- Release with bounce, then re-press during RELEASE -> back to HELD with no extra pulse. Clean release of 16+ clocks -> key_held=0 and scanning resumes at cols=1011.
- Rows 1 and 3 low together on col 0 -> key_code=4'b0100. While that key is held, pressing the key at row 0/col 0 -> ignored.
- Assert reset during DEBOUNCE at count 8 -> cols=1110, key_valid=0, key_held=0, key_code=0 immediately; after reset is released with the key still held, a full scan and debounce is needed before one pulse.
